pll_lock_sequencer: RTL

//  Closes the loop around an rPLL: consumes its asynchronous LOCK output and drives its RESET input.

---
 rtl/pll_seq_pkg.sv | 11 +
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAITLK = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser, async active-low reset to 0
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - drives rPLL RESET from its LOCK, gates downstream reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 27000,
    parameter int unsigned STABLE_CYCLES  = 2700,
    parameter int unsigned LOSS_FILTER    = 4,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       rst_out_n,
    output logic       locked_ok,
    output logic       fault,
    output logic [7:0] retry_count,
    output logic [1:0] state_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXP = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                        max2(STABLE_CYCLES, LOSS_FILTER));
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LF_LAST = CW'(LOSS_FILTER - 1);

    logic          lock_s;
    pll_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    retry_nxt;
    logic          retry_inc;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // cnt counts cycles spent in the current state; in RUN it counts contiguous unlocked cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        retry_inc = 1'b0;
        case (state)
            ST_PLLRST: if (cnt == PR_LAST) state_nxt = ST_WAITLK;
            ST_WAITLK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_PLLRST;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)              state_nxt = ST_WAITLK;
                else if (cnt == ST_LAST)  state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (lock_s)               cnt_nxt   = '0;
                else if (cnt == LF_LAST)  state_nxt = ST_PLLRST;
            end
            default: state_nxt = ST_PLLRST;
        endcase
        if (state_nxt != state) cnt_nxt = '0;

        retry_nxt = retry_count;
        if (retry_inc && retry_count != 8'hFF) retry_nxt = retry_count + 8'd1;
        if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PLLRST;
            cnt         <= '0;
            retry_count <= 8'd0;
            fault       <= 1'b0;
            pll_reset   <= 1'b1;
            rst_out_n   <= 1'b0;
            locked_ok   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            fault       <= fault | (32'(retry_nxt) >= MAX_RETRIES);
            pll_reset   <= (state_nxt == ST_PLLRST);
            rst_out_n   <= (state_nxt == ST_RUN);
            locked_ok   <= (state_nxt == ST_RUN);
        end
    end

    assign state_o = state;

endmodule
